// File: rtl/minterm_table_eval.sv
// minterm_table_eval: runtime-programmable sum-of-minterms evaluator with a
// one-cycle streaming evaluation path and an exhaustive count/compare sweep.
module minterm_table_eval #(
    parameter int N_IN  = 5,
    parameter int N_OUT = 3,
    parameter int CMP_A = 0,
    parameter int CMP_B = 1
) (
    input  logic                                        clk,
    input  logic                                        rst,
    input  logic                                        cfg_we,
    input  logic [((N_OUT > 1) ? $clog2(N_OUT) : 1)-1:0] cfg_sel,
    input  logic [N_IN-1:0]                             cfg_idx,
    input  logic                                        cfg_on,
    input  logic                                        cfg_dc,
    input  logic                                        dc_pol,
    input  logic                                        in_valid,
    input  logic [N_IN-1:0]                             in_vec,
    output logic                                        in_ready,
    output logic                                        out_valid,
    output logic [N_OUT-1:0]                            out_vec,
    input  logic                                        sweep_start,
    output logic                                        busy,
    output logic                                        done,
    output logic [N_OUT*(N_IN+1)-1:0]                   sweep_cnt,
    output logic                                        mismatch
);

    localparam int SEL_W = (N_OUT > 1) ? $clog2(N_OUT) : 1;
    localparam int DEPTH = 1 << N_IN;
    localparam int CW    = N_IN + 1;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SWEEP = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    logic [1:0]           r_state;
    logic [DEPTH-1:0]     r_on [N_OUT];
    logic [DEPTH-1:0]     r_dc [N_OUT];
    logic [N_IN-1:0]      r_idx;
    logic                 r_out_valid;
    logic [N_OUT-1:0]     r_out_vec;
    logic [N_OUT*CW-1:0]  r_cnt;
    logic                 r_mismatch;

    logic                 w_idle;
    logic                 w_accept;
    logic [N_OUT-1:0]     w_res_eval;
    logic [N_OUT-1:0]     w_res_sweep;
    logic                 w_cmp_diff;

    // DC entries take priority over ON and are replaced by the policy bit.
    function automatic logic f_resolve(input logic on_bit, input logic dc_bit, input logic pol);
        f_resolve = dc_bit ? pol : on_bit;
    endfunction

    assign w_idle   = (r_state == S_IDLE);
    assign w_accept = in_valid && w_idle;

    // Resolved function values for the eval vector and the sweep index, plus care-point compare.
    always_comb begin
        w_res_eval  = '0;
        w_res_sweep = '0;
        for (int j = 0; j < N_OUT; j++) begin
            w_res_eval[j]  = f_resolve(r_on[j][in_vec], r_dc[j][in_vec], dc_pol);
            w_res_sweep[j] = f_resolve(r_on[j][r_idx], r_dc[j][r_idx], dc_pol);
        end
        w_cmp_diff = !r_dc[CMP_A][r_idx] && !r_dc[CMP_B][r_idx] &&
                     (r_on[CMP_A][r_idx] != r_on[CMP_B][r_idx]);
    end

    // ON/DC tables; writes only land while idle so a sweep sees a frozen table.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int j = 0; j < N_OUT; j++) begin
                r_on[j] <= '0;
                r_dc[j] <= '0;
            end
        end else if (cfg_we && w_idle) begin
            for (int j = 0; j < N_OUT; j++) begin
                if (cfg_sel == SEL_W'(j)) begin
                    r_on[j][cfg_idx] <= cfg_on;
                    r_dc[j][cfg_idx] <= cfg_dc;
                end
            end
        end
    end

    // Sweep FSM: walks every minterm once, accumulating counts and the sticky mismatch.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= S_IDLE;
            r_idx      <= '0;
            r_cnt      <= '0;
            r_mismatch <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (sweep_start) begin
                        r_state    <= S_SWEEP;
                        r_idx      <= '0;
                        r_cnt      <= '0;
                        r_mismatch <= 1'b0;
                    end
                end
                S_SWEEP: begin
                    for (int j = 0; j < N_OUT; j++) begin
                        r_cnt[j*CW +: CW] <= r_cnt[j*CW +: CW] + CW'(w_res_sweep[j]);
                    end
                    if (w_cmp_diff) begin
                        r_mismatch <= 1'b1;
                    end
                    if (r_idx == {N_IN{1'b1}}) begin
                        r_state <= S_DONE;
                    end else begin
                        r_idx <= r_idx + N_IN'(1);
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Streaming evaluation result, one cycle after acceptance; value holds between pulses.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_out_valid <= 1'b0;
            r_out_vec   <= '0;
        end else begin
            r_out_valid <= w_accept;
            if (w_accept) begin
                r_out_vec <= w_res_eval;
            end
        end
    end

    assign in_ready  = w_idle;
    assign out_valid = r_out_valid;
    assign out_vec   = r_out_vec;
    assign busy      = (r_state == S_SWEEP);
    assign done      = (r_state == S_DONE);
    assign sweep_cnt = r_cnt;
    assign mismatch  = r_mismatch;

endmodule

// File: tb/tb_minterm_table_eval.sv
// Self-checking bench for minterm_table_eval: table-driven evaluation vectors,
// a scoreboard for the streaming path, and hand-written sweep corner cases.
module tb_minterm_table_eval;

    logic        clk;
    logic        rst;
    logic        cfg_we;
    logic [1:0]  cfg_sel;
    logic [4:0]  cfg_idx;
    logic        cfg_on;
    logic        cfg_dc;
    logic        dc_pol;
    logic        in_valid;
    logic [4:0]  in_vec;
    logic        in_ready;
    logic        out_valid;
    logic [2:0]  out_vec;
    logic        sweep_start;
    logic        busy;
    logic        done;
    logic [17:0] sweep_cnt;
    logic        mismatch;

    int n_checks = 0;
    int n_errors = 0;

    logic [31:0] m_on [3];
    logic [31:0] m_dc [3];
    bit          m_idle;
    logic [2:0]  sb [$];

    typedef struct {
        logic [4:0] vec;
        logic       pol;
        logic [2:0] exp;
    } vec_t;

    minterm_table_eval #(.N_IN(5), .N_OUT(3), .CMP_A(0), .CMP_B(1)) dut (
        .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_sel(cfg_sel), .cfg_idx(cfg_idx),
        .cfg_on(cfg_on), .cfg_dc(cfg_dc), .dc_pol(dc_pol), .in_valid(in_valid),
        .in_vec(in_vec), .in_ready(in_ready), .out_valid(out_valid), .out_vec(out_vec),
        .sweep_start(sweep_start), .busy(busy), .done(done), .sweep_cnt(sweep_cnt),
        .mismatch(mismatch)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [2:0] model(input logic [4:0] v, input logic p);
        logic [2:0] r;
        for (int j = 0; j < 3; j++) r[j] = m_dc[j][v] ? p : m_on[j][v];
        return r;
    endfunction

    task automatic clear_model();
        for (int j = 0; j < 3; j++) begin
            m_on[j] = 32'd0;
            m_dc[j] = 32'd0;
        end
    endtask

    // One clock: push expectation on accept, update model table, then score any output.
    task automatic step();
        bit acc;
        acc = in_valid && m_idle && !rst;
        if (acc) sb.push_back(model(in_vec, dc_pol));
        if (cfg_we && m_idle && !rst && cfg_sel != 2'd3) begin
            m_on[cfg_sel][cfg_idx] = cfg_on;
            m_dc[cfg_sel][cfg_idx] = cfg_dc;
        end
        @(posedge clk);
        #1;
        if (out_valid) begin
            if (sb.size() == 0) chk("unexpected_out_valid", 32'd1, 32'd0);
            else chk("sb_out_vec", 32'(out_vec), 32'(sb.pop_front()));
        end else if (sb.size() != 0) begin
            chk("missing_out_valid", 32'd0, 32'd1);
            sb.delete();
        end
    endtask

    task automatic wr(input logic [1:0] sel, input logic [4:0] idx, input logic on, input logic dc);
        cfg_we = 1'b1; cfg_sel = sel; cfg_idx = idx; cfg_on = on; cfg_dc = dc;
        step();
        cfg_we = 1'b0;
    endtask

    task automatic eval1(input string name, input logic [4:0] v, input logic p, input logic [2:0] exp);
        in_valid = 1'b1; in_vec = v; dc_pol = p;
        step();
        in_valid = 1'b0;
        chk(name, 32'(out_vec), 32'(exp));
    endtask

    task automatic chk_counts(input string name, input int c0, input int c1, input int c2, input int mis);
        chk({name, "_cnt0"}, 32'(sweep_cnt[5:0]), c0);
        chk({name, "_cnt1"}, 32'(sweep_cnt[11:6]), c1);
        chk({name, "_cnt2"}, 32'(sweep_cnt[17:12]), c2);
        chk({name, "_mismatch"}, 32'(mismatch), mis);
    endtask

    // Run one sweep (with an eval in the start cycle); optionally disturb or reset mid-sweep.
    task automatic run_sweep(input int disturb_at, input int reset_at);
        int  nb, nd, extra;
        bit  aborted;
        nb = 0; nd = 0; extra = 0; aborted = 1'b0;
        sweep_start = 1'b1; in_valid = 1'b1; in_vec = 5'd4;
        step();
        sweep_start = 1'b0; in_valid = 1'b0; m_idle = 1'b0;
        for (int c = 0; c < 40; c++) begin
            if (c == reset_at) begin
                rst = 1'b1;
                #1;
                chk("rst_out_valid", 32'(out_valid), 32'd0);
                chk("rst_out_vec", 32'(out_vec), 32'd0);
                chk("rst_busy", 32'(busy), 32'd0);
                chk("rst_done", 32'(done), 32'd0);
                chk("rst_sweep_cnt", 32'(sweep_cnt), 32'd0);
                chk("rst_mismatch", 32'(mismatch), 32'd0);
                sb.delete();
                clear_model();
                @(posedge clk);
                #1;
                rst = 1'b0;
                m_idle = 1'b1;
                aborted = 1'b1;
                break;
            end
            if (busy) nb++;
            if (done) begin
                nd++;
                break;
            end
            if (c == disturb_at) begin
                cfg_we = 1'b1; cfg_sel = 2'd0; cfg_idx = 5'd2; cfg_on = 1'b0; cfg_dc = 1'b1;
                in_valid = 1'b1; in_vec = 5'd2; sweep_start = 1'b1;
                chk("sweep_in_ready_low", 32'(in_ready), 32'd0);
            end
            step();
            cfg_we = 1'b0; in_valid = 1'b0; sweep_start = 1'b0;
        end
        if (aborted) begin
            for (int k = 0; k < 40; k++) begin
                if (done || busy) extra++;
                step();
            end
            chk("no_done_after_rst", extra, 0);
        end else begin
            chk("busy_cycles", nb, 32);
            chk("done_seen", nd, 1);
            step();
            chk("done_one_cycle", 32'(done), 32'd0);
            m_idle = 1'b1;
            if (disturb_at >= 0) begin
                for (int k = 0; k < 40; k++) begin
                    if (done || busy) extra++;
                    step();
                end
                chk("no_second_sweep", extra, 0);
            end
        end
    endtask

    initial begin
        vec_t tv [8];
        int   on_list [12] = '{2, 3, 4, 6, 10, 11, 15, 17, 18, 21, 25, 27};
        int   dc_list [4]  = '{0, 8, 19, 23};

        rst = 1'b1; cfg_we = 1'b0; cfg_sel = 2'd0; cfg_idx = 5'd0; cfg_on = 1'b0;
        cfg_dc = 1'b0; dc_pol = 1'b0; in_valid = 1'b0; in_vec = 5'd0; sweep_start = 1'b0;
        m_idle = 1'b1;
        clear_model();

        step();
        step();
        chk("reset_out_valid", 32'(out_valid), 32'd0);
        chk("reset_out_vec", 32'(out_vec), 32'd0);
        chk("reset_busy", 32'(busy), 32'd0);
        chk("reset_done", 32'(done), 32'd0);
        chk("reset_cnt", 32'(sweep_cnt), 32'd0);
        chk("reset_mismatch", 32'(mismatch), 32'd0);
        chk("reset_in_ready", 32'(in_ready), 32'd1);
        rst = 1'b0;
        step();

        // Test 1: program out0 and stream back-to-back evaluations.
        foreach (on_list[i]) wr(2'd0, 5'(on_list[i]), 1'b1, 1'b0);
        foreach (dc_list[i]) wr(2'd0, 5'(dc_list[i]), 1'b0, 1'b1);
        wr(2'd3, 5'd5, 1'b1, 1'b0);
        tv[0] = '{5'd4,  1'b0, 3'b001};
        tv[1] = '{5'd5,  1'b0, 3'b000};
        tv[2] = '{5'd0,  1'b0, 3'b000};
        tv[3] = '{5'd0,  1'b1, 3'b001};
        tv[4] = '{5'd8,  1'b1, 3'b001};
        tv[5] = '{5'd19, 1'b0, 3'b000};
        tv[6] = '{5'd27, 1'b0, 3'b001};
        tv[7] = '{5'd31, 1'b1, 3'b000};
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1; in_vec = tv[i].vec; dc_pol = tv[i].pol;
            step();
            chk("tbl_out_valid", 32'(out_valid), 32'd1);
            chk("tbl_out_vec", 32'(out_vec), 32'(tv[i].exp));
        end
        in_valid = 1'b0;
        step();
        chk("valid_drop", 32'(out_valid), 32'd0);
        chk("out_vec_hold", 32'(out_vec), 32'd0);

        // Test 2: out1 = ON plus out0's DC points, no DC of its own.
        foreach (on_list[i]) wr(2'd1, 5'(on_list[i]), 1'b1, 1'b0);
        foreach (dc_list[i]) wr(2'd1, 5'(dc_list[i]), 1'b1, 1'b0);
        dc_pol = 1'b0;
        run_sweep(-1, -1);
        chk_counts("sweep_pol0", 12, 16, 0, 0);
        dc_pol = 1'b1;
        run_sweep(-1, -1);
        chk_counts("sweep_pol1", 16, 16, 0, 0);

        // Test 3: clear out1[15] with an eval of the same index in the same cycle.
        dc_pol = 1'b0;
        cfg_we = 1'b1; cfg_sel = 2'd1; cfg_idx = 5'd15; cfg_on = 1'b0; cfg_dc = 1'b0;
        in_valid = 1'b1; in_vec = 5'd15;
        step();
        cfg_we = 1'b0; in_valid = 1'b0;
        chk("eval_prewrite", 32'(out_vec), 32'd3);
        eval1("eval_postwrite", 5'd15, 1'b0, 3'b001);
        run_sweep(-1, -1);
        chk_counts("sweep_clr15", 12, 15, 0, 1);
        wr(2'd1, 5'd15, 1'b0, 1'b1);
        run_sweep(-1, -1);
        chk_counts("sweep_dc15", 12, 15, 0, 0);

        // Test 4: all-true output counts to 32 without overflow.
        for (int i = 0; i < 32; i++) wr(2'd2, 5'(i), 1'b1, 1'b0);
        run_sweep(-1, -1);
        chk_counts("sweep_full", 12, 15, 32, 0);

        // Test 5: writes, evals and a second start during a sweep are ignored.
        run_sweep(3, -1);
        chk_counts("sweep_disturb", 12, 15, 32, 0);
        eval1("table_frozen", 5'd2, 1'b0, 3'b111);

        // Test 6: reset at sweep cycle 10 aborts and clears everything.
        run_sweep(-1, 10);
        eval1("table_cleared", 5'd4, 1'b0, 3'b000);
        run_sweep(-1, -1);
        chk_counts("sweep_after_rst", 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/minterm_table_eval.md
Name: minterm_table_eval

Overview:
- Programmable sum-of-minterms evaluator. Generalises our fixed 5-input minterm logic to N_IN inputs and N_OUT outputs.
- Each output has a runtime-loaded ON table and DON'T-CARE (DC) table of 2^N_IN bits. A resolution policy selects the value used for DC entries.
- Two uses:
  - Streaming single-vector evaluation through a valid/ready handshake.
  - A sweep engine that walks all 2^N_IN minterms, counts true entries per output, and flags care-point disagreement between two chosen outputs.

Parameters:
- N_IN, 5, number of function inputs; table depth is 2^N_IN.
- N_OUT, 3, number of independent output functions.
- CMP_A, 0, first output index compared during sweep.
- CMP_B, 1, second output index compared during sweep; must differ from CMP_A and be < N_OUT.

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  reset, asynchronous, active-high.
- cfg_we  input  1  table write strobe.
- cfg_sel  input  max(1,clog2(N_OUT))  output function selected for write.
- cfg_idx  input  N_IN  minterm index written.
- cfg_on  input  1  ON bit written.
- cfg_dc  input  1  DC bit written.
- dc_pol  input  1  value substituted for DC entries, for both eval and sweep.
- in_valid  input  1  evaluation request.
- in_vec  input  N_IN  input vector; bit N_IN-1 is MSB of the minterm index.
- in_ready  output  1  block can accept a request.
- out_valid  output  1  out_vec valid, one-cycle pulse.
- out_vec  output  N_OUT  evaluated function values.
- sweep_start  input  1  start exhaustive sweep.
- busy  output  1  sweep in progress.
- done  output  1  one-cycle pulse at sweep end.
- sweep_cnt  output  N_OUT*(N_IN+1)  packed per-output true counts; output j occupies bits [j*(N_IN+1) +: N_IN+1].
- mismatch  output  1  sticky flag: CMP_A and CMP_B differ at a mutual care point.

Behaviour:

Reset (asynchronous assert; release is synchronous to clk):
- All ON and DC bits = 0.
- FSM = IDLE, sweep index = 0.
- out_valid = 0, out_vec = 0, done = 0, busy = 0, sweep_cnt = 0, mismatch = 0.
- Reset asserted mid-sweep aborts the sweep immediately. No done pulse follows.

Resolved value of output j at index i: res = DC[j][i] ? dc_pol : ON[j][i]. DC takes priority over ON.

Config write:
- Applies on the clock edge when cfg_we=1 and FSM=IDLE.
- cfg_we is ignored while FSM != IDLE; the table is frozen during a sweep.
- cfg_sel >= N_OUT: write ignored.
- A write and an eval of the same index in the same cycle: the eval sees the pre-write contents.

Evaluation:
- in_ready = (FSM==IDLE), combinational from state.
- A request is accepted when in_valid && in_ready.
- Next cycle: out_valid=1 and out_vec[j]=res(j,in_vec). Latency is exactly 1 cycle.
- Back-to-back accepts give back-to-back out_valid.
- No output backpressure.
- out_vec holds its last value when out_valid=0.

FSM states: IDLE, SWEEP, DONE.
- IDLE -> SWEEP on sweep_start.
  - Clears sweep index, all counts and mismatch.
  - sweep_start in any other state is ignored.
  - sweep_start and an accepted eval in the same IDLE cycle are both honoured.
- SWEEP:
  - busy=1.
  - Each cycle evaluates index k, adds res(j,k) to count j, and updates mismatch.
  - mismatch sets when !DC[A][k] && !DC[B][k] && ON[A][k]!=ON[B][k].
  - k increments each cycle. After k=2^N_IN-1 is processed -> DONE. No wrap.
- DONE: done=1 for one cycle, busy=0, -> IDLE.
- Timing: sweep_start sampled at edge t; busy high for exactly 2^N_IN cycles; done high in the cycle after the last busy cycle.
- Counts are N_IN+1 bits so all-true (2^N_IN) fits without overflow.
- sweep_cnt and mismatch hold until the next sweep_start or reset.
- dc_pol is sampled every sweep cycle; it must be held stable during a sweep.

Test Plan:
1. Program out0:
   - ON = {2,3,4,6,10,11,15,17,18,21,25,27}, DC = {0,8,19,23}.
   - Evaluate with dc_pol=0: in_vec=4 -> out_vec[0]=1; in_vec=5 -> 0; in_vec=0 -> 0.
   - With dc_pol=1: in_vec=0 -> 1.
   - out_valid asserts exactly one cycle after each accept.
2. out0 as in 1; out1 ON = the 12 ON minterms plus {0,8,19,23}, no DC. Sweep with dc_pol=0:
   - busy for 32 cycles, done pulse once.
   - cnt0=12, cnt1=16, cnt2=0, mismatch=0.
   - Repeat with dc_pol=1: cnt0=16.
3. Clear out1[15] and rerun the sweep -> mismatch=1, cnt1=15.
   - Set out1 DC[15]=1 instead -> mismatch=0.
4. Program out2 all 32 ON, sweep -> cnt2=32 (6'b100000), no overflow.
5. During a sweep:
   - Pulse cfg_we at index 2 and in_valid: table unchanged, in_ready=0, no out_valid.
   - Second sweep_start is ignored; done fires only once.
6. Assert rst at sweep cycle 10:
   - Outputs and table return to reset values immediately; no done.
   - A fresh sweep reports all counts 0.
